// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with saturating counters and misprediction statistics
module branch_target_predictor #(
  parameter int ENTRIES      = 16,
  parameter int COUNTER_BITS = 2,
  parameter int MODE         = 1,
  parameter int STAT_BITS    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          lookupPC,
  output logic                 hit,
  output logic                 predTaken,
  output logic [31:0]          predTarget,
  input  logic                 updValid,
  input  logic [31:0]          updPC,
  input  logic                 updTaken,
  input  logic [31:0]          updTarget,
  input  logic                 updPredTaken,
  input  logic [31:0]          updPredTarget,
  output logic                 mispredict,
  input  logic                 flush,
  output logic [STAT_BITS-1:0] branchCount,
  output logic [STAT_BITS-1:0] mispredictCount
);
  localparam int IB = $clog2(ENTRIES);
  localparam int TB = 30 - IB;
  localparam logic [COUNTER_BITS-1:0] CTR_MAX = '1;
  localparam logic [COUNTER_BITS-1:0] CTR_WEAK = COUNTER_BITS'(1) << (COUNTER_BITS - 1);
  logic [ENTRIES-1:0] valid;
  logic [TB-1:0] tags [ENTRIES];
  logic [31:0] tgts [ENTRIES];
  logic [COUNTER_BITS-1:0] ctrs [ENTRIES];
  logic [IB-1:0] lk_idx, up_idx;
  logic [TB-1:0] lk_tag, up_tag;
  logic up_hit, mis;
  logic [COUNTER_BITS-1:0] up_ctr, ctr_nxt;
  assign lk_idx = lookupPC[IB+1:2];
  assign lk_tag = lookupPC[31:IB+2];
  assign up_idx = updPC[IB+1:2];
  assign up_tag = updPC[31:IB+2];
  assign hit = (MODE == 1) && valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign predTaken = hit && ctrs[lk_idx][COUNTER_BITS-1];
  assign predTarget = predTaken ? tgts[lk_idx] : 32'h0;
  assign up_hit = valid[up_idx] && (tags[up_idx] == up_tag);
  assign up_ctr = ctrs[up_idx];
  assign mis = (updPredTaken != updTaken) || (updTaken && updPredTaken && (updPredTarget != updTarget));
  // saturating counter step toward the resolved outcome
  always_comb begin
    ctr_nxt = updTaken ? ((up_ctr == CTR_MAX) ? CTR_MAX : up_ctr + 1'b1)
                       : ((up_ctr == '0) ? '0 : up_ctr - 1'b1);
  end
  // table write: flush wins over a same-cycle update; misses only allocate on taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tags[i] <= '0;
        tgts[i] <= '0;
        ctrs[i] <= '0;
      end
    end else if (flush) begin
      valid <= '0;
    end else if (updValid && MODE == 1) begin
      if (up_hit) begin
        ctrs[up_idx] <= ctr_nxt;
        if (updTaken) tgts[up_idx] <= updTarget;
      end else if (updTaken) begin
        valid[up_idx] <= 1'b1;
        tags[up_idx] <= up_tag;
        tgts[up_idx] <= updTarget;
        ctrs[up_idx] <= CTR_WEAK;
      end
    end
  end
  // misprediction flag and saturating statistics, independent of mode and flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict <= 1'b0;
      branchCount <= '0;
      mispredictCount <= '0;
    end else begin
      mispredict <= updValid && mis;
      if (updValid && !(&branchCount)) branchCount <= branchCount + 1'b1;
      if (updValid && mis && !(&mispredictCount)) mispredictCount <= mispredictCount + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: directed vector table plus hand sequences for flush, reset, mode 0 and stat saturation
module tb_branch_target_predictor;
  localparam logic [31:0] A  = 32'h0040_0010;
  localparam logic [31:0] B  = 32'h0040_0050;
  localparam logic [31:0] C  = 32'h0040_0080;
  localparam logic [31:0] T1 = 32'h0040_0100;
  localparam logic [31:0] T2 = 32'h0040_0200;
  localparam logic [31:0] T3 = 32'h0040_0300;
  localparam int NV = 25;
  typedef struct {
    logic uv; logic [31:0] upc; logic ut; logic [31:0] utgt; logic upt; logic [31:0] uptgt;
    logic [31:0] lpc; logic e_hit; logic e_pt; logic [31:0] e_tgt; logic e_mis;
  } vec_t;
  logic clk = 0, rst_n = 0;
  logic [31:0] lookupPC = 0, updPC = 0, updTarget = 0, updPredTarget = 0;
  logic updValid = 0, updTaken = 0, updPredTaken = 0, flush = 0;
  logic hit, predTaken, mispredict;
  logic [31:0] predTarget, branchCount, mispredictCount;
  logic [31:0] s_upc = 0, s_utgt = 0;
  logic s_uv = 0, s_ut = 0;
  logic m0_hit, m0_pt, m0_mis, s4_hit, s4_pt, s4_mis;
  logic [31:0] m0_tgt, m0_bc, m0_mc, s4_tgt;
  logic [3:0] s4_bc, s4_mc;
  int n_vec = 0, n_bad = 0;
  vec_t tv [NV];
  always #5 clk = ~clk;
  branch_target_predictor dut (
    .clk(clk), .rst_n(rst_n), .lookupPC(lookupPC), .hit(hit), .predTaken(predTaken), .predTarget(predTarget),
    .updValid(updValid), .updPC(updPC), .updTaken(updTaken), .updTarget(updTarget), .updPredTaken(updPredTaken),
    .updPredTarget(updPredTarget), .mispredict(mispredict), .flush(flush), .branchCount(branchCount),
    .mispredictCount(mispredictCount));
  branch_target_predictor #(.MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .lookupPC(s_upc), .hit(m0_hit), .predTaken(m0_pt), .predTarget(m0_tgt),
    .updValid(s_uv), .updPC(s_upc), .updTaken(s_ut), .updTarget(s_utgt), .updPredTaken(1'b0),
    .updPredTarget(32'h0), .mispredict(m0_mis), .flush(1'b0), .branchCount(m0_bc), .mispredictCount(m0_mc));
  branch_target_predictor #(.STAT_BITS(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .lookupPC(s_upc), .hit(s4_hit), .predTaken(s4_pt), .predTarget(s4_tgt),
    .updValid(s_uv), .updPC(s_upc), .updTaken(s_ut), .updTarget(s_utgt), .updPredTaken(1'b0),
    .updPredTarget(32'h0), .mispredict(s4_mis), .flush(1'b0), .branchCount(s4_bc), .mispredictCount(s4_mc));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                              input logic upt, input logic [31:0] uptgt, input logic [31:0] lpc,
                              input logic eh, input logic ep, input logic [31:0] et, input logic em);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upt = upt; v.uptgt = uptgt;
    v.lpc = lpc; v.e_hit = eh; v.e_pt = ep; v.e_tgt = et; v.e_mis = em;
    return v;
  endfunction
  task automatic idle();
    updValid = 0; updTaken = 0; updPredTaken = 0; flush = 0;
  endtask
  initial begin
    tv[0] = mk(1, A, 1, T1, 0, 0, A, 0, 0, 0, 1);
    tv[1] = mk(0, A, 0, 0, 0, 0, A, 1, 1, T1, 0);
    tv[2] = mk(1, A, 1, T1, 1, T1, A, 1, 1, T1, 0);
    tv[3] = mk(1, A, 1, T1, 1, T1, A, 1, 1, T1, 0);
    tv[4] = mk(1, A, 1, T1, 1, T1, A, 1, 1, T1, 0);
    tv[5] = mk(1, A, 0, 0, 1, T1, A, 1, 1, T1, 1);
    tv[6] = mk(1, A, 0, 0, 1, T1, A, 1, 1, T1, 1);
    tv[7] = mk(0, A, 0, 0, 0, 0, A, 1, 0, 0, 0);
    for (int i = 8; i < 18; i++) tv[i] = mk(1, A, 0, 0, 0, 0, A, 1, 0, 0, 0);
    tv[18] = mk(1, A, 1, T1, 0, 0, A, 1, 0, 0, 1);
    tv[19] = mk(0, A, 0, 0, 0, 0, A, 1, 0, 0, 0);
    tv[20] = mk(1, B, 1, T2, 0, 0, A, 1, 0, 0, 1);
    tv[21] = mk(0, B, 0, 0, 0, 0, A, 0, 0, 0, 0);
    tv[22] = mk(0, B, 0, 0, 0, 0, B, 1, 1, T2, 0);
    tv[23] = mk(1, B, 1, T3, 1, T2, B, 1, 1, T2, 1);
    tv[24] = mk(0, B, 0, 0, 0, 0, B, 1, 1, T3, 0);
    lookupPC = A;
    repeat (2) @(negedge clk);
    chk("reset_hit", {31'b0, hit}, 0);
    chk("reset_pt", {31'b0, predTaken}, 0);
    chk("reset_tgt", predTarget, 0);
    chk("reset_mis", {31'b0, mispredict}, 0);
    chk("reset_bc", branchCount, 0);
    rst_n = 1;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      updValid = tv[i].uv; updPC = tv[i].upc; updTaken = tv[i].ut; updTarget = tv[i].utgt;
      updPredTaken = tv[i].upt; updPredTarget = tv[i].uptgt; lookupPC = tv[i].lpc;
      #1;
      chk($sformatf("v%0d_hit", i), {31'b0, hit}, {31'b0, tv[i].e_hit});
      chk($sformatf("v%0d_pt", i), {31'b0, predTaken}, {31'b0, tv[i].e_pt});
      chk($sformatf("v%0d_tgt", i), predTarget, tv[i].e_tgt);
      @(posedge clk); #1;
      chk($sformatf("v%0d_mis", i), {31'b0, mispredict}, {31'b0, tv[i].e_mis});
    end
    @(negedge clk);
    idle();
    chk("tbl_bc", branchCount, 19);
    chk("tbl_mc", mispredictCount, 6);
    updValid = 1; updPC = C; updTaken = 1; updTarget = T1; updPredTaken = 0; flush = 1; lookupPC = B;
    #1 chk("flush_pre_hit", {31'b0, hit}, 1);
    @(negedge clk);
    idle();
    chk("flush_b_hit", {31'b0, hit}, 0);
    chk("flush_mis", {31'b0, mispredict}, 1);
    chk("flush_bc", branchCount, 20);
    chk("flush_mc", mispredictCount, 7);
    lookupPC = C;
    #1 chk("flush_c_hit", {31'b0, hit}, 0);
    @(negedge clk);
    chk("mis_clear", {31'b0, mispredict}, 0);
    updValid = 1; updPC = A; updTaken = 1; updTarget = T2; updPredTaken = 1; updPredTarget = T2; lookupPC = A;
    @(negedge clk);
    idle();
    chk("realloc_hit", {31'b0, hit}, 1);
    chk("realloc_tgt", predTarget, T2);
    #3 rst_n = 0;
    #1;
    chk("async_hit", {31'b0, hit}, 0);
    chk("async_pt", {31'b0, predTaken}, 0);
    chk("async_tgt", predTarget, 0);
    chk("async_bc", branchCount, 0);
    chk("async_mc", mispredictCount, 0);
    @(negedge clk);
    rst_n = 1;
    s_upc = A; s_utgt = T1; s_ut = 1;
    for (int i = 0; i < 20; i++) begin
      s_uv = 1;
      #1 chk($sformatf("m0_hit%0d", i), {31'b0, m0_hit}, 0);
      @(negedge clk);
    end
    s_uv = 0;
    chk("m0_hit_end", {31'b0, m0_hit}, 0);
    chk("m0_tgt_end", m0_tgt, 0);
    chk("m0_mc", m0_mc, 20);
    chk("m0_bc", m0_bc, 20);
    chk("s4_bc", {28'b0, s4_bc}, 15);
    chk("s4_mc", {28'b0, s4_mc}, 15);
    chk("s4_pt", {31'b0, s4_pt}, 1);
    chk("s4_tgt", s4_tgt, T1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised dynamic branch predictor for the pipelined MIPS CPU's IF stage; generalises the current fixed "predict not-taken, flush on taken" control-hazard handling.
- Direct-mapped branch target buffer (BTB) with per-entry saturating counters of configurable width, a selectable static/dynamic mode and misprediction statistics.
- IF stage looks up the fetch PC each cycle. EX stage writes back each resolved branch/jump.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 2..256; INDEX_BITS = log2(ENTRIES).
- COUNTER_BITS, 2, saturating counter width, 1..4.
- MODE, 1, 0 = static not-taken (table inert), 1 = dynamic counter prediction.
- STAT_BITS, 32, width of statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lookupPC  in  32  IF-stage fetch PC.
- hit  out  1  lookupPC matches a valid entry.
- predTaken  out  1  predict taken.
- predTarget  out  32  predicted target; valid when predTaken=1, otherwise 0.
- updValid  in  1  EX resolved a control-transfer instruction this cycle.
- updPC  in  32  PC of the resolved instruction.
- updTaken  in  1  actual outcome.
- updTarget  in  32  actual target.
- updPredTaken  in  1  prediction that was carried down the pipe with the instruction.
- updPredTarget  in  32  predicted target carried down the pipe.
- mispredict  out  1  registered; 1 for one cycle after a mispredicted update.
- flush  in  1  synchronous invalidate of the whole table.
- branchCount  out  STAT_BITS  resolved updates counted.
- mispredictCount  out  STAT_BITS  mispredictions counted.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All valid bits, tags, targets and counters go to 0.
  - mispredict, branchCount and mispredictCount go to 0.
  - hit, predTaken and predTarget therefore read 0.
- Addressing: index = PC[INDEX_BITS+1:2]; tag = PC[31:INDEX_BITS+2]. PC[1:0] is ignored.
- Lookup is combinational (zero latency):
  - hit = valid[index] && tag match.
  - predTaken = hit && counter MSB.
  - predTarget = target when predTaken, else 0.
- Update on a rising edge when updValid=1, MODE=1 and flush=0:
  - Hit, taken: counter saturating increment (max 2^COUNTER_BITS-1); target overwritten with updTarget.
  - Hit, not taken: counter saturating decrement (min 0); target unchanged; entry stays valid.
  - Miss, taken: allocate the entry (replace any occupant). valid=1, tag, target=updTarget, counter = 2^(COUNTER_BITS-1) (weakly taken).
  - Miss, not taken: no table change.
- Misprediction:
  - Condition: updPredTaken != updTaken, or (updTaken && updPredTaken && updPredTarget != updTarget).
  - Registered into mispredict on the edge. mispredict is 0 on any cycle without updValid.
- Statistics:
  - Any updValid edge increments branchCount; a mispredicted one also increments mispredictCount.
  - Both saturate at all-ones and never wrap.
  - Statistics update in both modes and are unaffected by flush.
- Read-before-write: a lookup and an update to the same index in the same cycle return the old contents. The new contents are visible from the next cycle.
- flush=1: all valid bits clear on the edge; counters and targets are don't-care. flush beats a same-cycle table update, but the statistics and mispredict from that update still register.
- MODE=0: table never written; hit = predTaken = 0 and predTarget = 0 always; mispredict/statistics still computed from the upd* inputs.
- COUNTER_BITS=1: counter behaves as a last-outcome bit; allocation sets it to 1.
- Aliasing: two PCs with equal index and different tag replace each other. No associativity.

Test Plan:
- Reset mid-operation: after allocating PC 0x0040_0010, pull rst_n low asynchronously between edges -> hit, predTaken, predTarget, branchCount and mispredictCount read 0 immediately.
- Allocation and prediction (ENTRIES=16, COUNTER_BITS=2): update PC 0x0040_0010 taken → 0x0040_0100 with updPredTaken=0 -> next cycle mispredict=1, mispredictCount=1. Lookup 0x0040_0010 gives hit=1, predTaken=1, predTarget=0x0040_0100.
- Saturation/hysteresis: from counter=2 apply taken ×3 then not-taken ×1 -> predTaken stays 1. A second not-taken gives predTaken=0 with hit=1. Ten not-takens leave the counter at 0 (no wrap).
- Aliasing and read-before-write:
  - Allocate 0x0040_0010, then update 0x0040_0050 (same index) taken → 0x0040_0200.
  - In the update cycle, a lookup of 0x0040_0010 still hits.
  - Next cycle, 0x0040_0010 misses and 0x0040_0050 hits with target 0x0040_0200.
- Flush vs update: assert flush and a taken miss update in the same cycle -> table empty afterwards (hit=0); branchCount still increments.
- MODE=0 and statistics saturation:
  - MODE=0: 20 taken updates with updPredTaken=0 give hit=0 throughout and mispredictCount=20.
  - STAT_BITS=4: 20 updates leave branchCount=15.
